// File: rtl/sao_pkg.sv
// ---------------------------------------------------------------------------
// sao_pkg : shared constants and helpers for the SAO statistics datapath
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sao_pkg;

  localparam logic [1:0] CIDX_Y  = 2'd0;
  localparam logic [1:0] CIDX_CB = 2'd1;
  localparam logic [1:0] CIDX_CR = 2'd2;

  localparam int FLG_WORKING     = 0;
  localparam int FLG_WAIT_PRE    = 1;
  localparam int FLG_NOT_END     = 2;
  localparam int FLG_NOT_END_PRE = 3;
  localparam int FLAG_BITS       = 4;

  localparam int MAX_PIX = 16;

  // Bit i set when pixel i lies below both the beat's valid count and the beat width.
  function automatic logic [MAX_PIX-1:0] npix_to_mask(input int npix, input int n_pix);
    logic [MAX_PIX-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PIX; i++) begin
      if (i < npix && i < n_pix) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sao_stat_pipe_slot.sv
// ---------------------------------------------------------------------------
// sao_stat_pipe_slot : one valid+payload register of the elastic stat pipe
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sao_stat_pipe_slot
  import sao_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // An invalid slot always carries a zero payload.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= valid_i;
      data_q  <= valid_i ? data_i : '0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/sao_stat_pipe_elastic.sv
// ---------------------------------------------------------------------------
// sao_stat_pipe_elastic : back-pressured SAO stat pipe with pixel masking,
//                         synchronous flush and occupancy reporting
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sao_stat_pipe_elastic
  import sao_pkg::*;
#(
  parameter int N_PIX     = 4,
  parameter int DIFF_BITS = 4,
  parameter int DEPTH     = 2,
  parameter int MASK_EN   = 1
) (
  input  logic                                 clk,
  input  logic                                 arst,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [N_PIX*(DIFF_BITS+1)-1:0] in_diff,
  input  logic [$clog2(N_PIX+1)-1:0]           in_npix,
  input  logic [1:0]                           in_cidx,
  input  logic [FLAG_BITS-1:0]                 in_flags,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [N_PIX*(DIFF_BITS+1)-1:0] out_diff,
  output logic [N_PIX-1:0]                     out_pix_mask,
  output logic [1:0]                           out_cidx,
  output logic [FLAG_BITS-1:0]                 out_flags,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy
);

  localparam int DW = DIFF_BITS + 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = FLAG_BITS + 2 + N_PIX + N_PIX * DW;

  logic [N_PIX-1:0]    mask_in;
  logic [N_PIX*DW-1:0] diff_in_m;
  logic [PW-1:0]       in_pl;

  logic [DEPTH-1:0]    v;
  logic [PW-1:0]       pl [DEPTH];
  logic [DEPTH-1:0]    load;
  logic                chain;

  logic                accept;
  logic                take;
  logic [OW-1:0]       occ_q;
  logic [OW-1:0]       occ_d;

  always_comb begin
    mask_in   = '1;
    diff_in_m = in_diff;
    if (MASK_EN != 0) begin
      mask_in = N_PIX'(npix_to_mask(int'(in_npix), N_PIX));
      for (int i = 0; i < N_PIX; i++) begin
        diff_in_m[i*DW +: DW] = mask_in[i] ? in_diff[i*DW +: DW] : '0;
      end
    end
  end

  assign in_pl = {in_flags, in_cidx, mask_in, diff_in_m};

  // Ready ripples from the consumer back to slot 0; any empty slot downstream
  // lets everything behind it move, so bubbles collapse in one edge.
  always_comb begin
    chain = out_ready;
    load  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain   = !v[k] || chain;
      load[k] = chain;
    end
  end

  assign in_ready = load[0] && !flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic          src_v;
    logic [PW-1:0] src_pl;

    if (k == 0) begin : g_head
      assign src_v  = in_valid;
      assign src_pl = in_pl;
    end else begin : g_body
      assign src_v  = v[k-1];
      assign src_pl = pl[k-1];
    end

    sao_stat_pipe_slot #(
      .W (PW)
    ) u_slot (
      .clk     (clk),
      .arst    (arst),
      .clr_i   (flush),
      .load_i  (load[k]),
      .valid_i (src_v),
      .data_i  (src_pl),
      .valid_o (v[k]),
      .data_o  (pl[k])
    );
  end

  // Beats are never created or lost inside the pipe, so the count only moves
  // on the two external handshakes.
  assign accept = in_valid && in_ready;
  assign take   = v[DEPTH-1] && out_ready;

  always_comb begin
    occ_d = occ_q + OW'(accept) - OW'(take);
    if (flush) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign out_valid = v[DEPTH-1];
  assign {out_flags, out_cidx, out_pix_mask, out_diff} = pl[DEPTH-1];

endmodule

`default_nettype wire
